// File: rtl/shift_unit_arbiter.sv
// Two-requester front end for a shared barrel shifter: round-robin grant, opcode
// decode, two-pass rotate-right sequencing and a single tagged response channel.

module barrel_shifter #(
    parameter int N = 32,
    parameter int B = $clog2(N)
) (
    input  logic [N-1:0] din,
    input  logic [B-1:0] amt,
    input  logic         lbarr,
    input  logic         asr,
    output logic [N-1:0] dout
);
    logic fill;
    assign fill = lbarr & asr & din[N-1];

    // Stage gi shifts by 2**gi when amt[gi] is set; right shifts back-fill with fill.
    for (genvar gi = 0; gi < B; gi++) begin : g_stage
        localparam int SH = 1 << gi;
        logic [N-1:0] in_w;
        logic [N-1:0] shl_w;
        logic [N-1:0] shr_w;
        logic [N-1:0] out_w;
        if (gi == 0) begin : g_first
            assign in_w = din;
        end else begin : g_rest
            assign in_w = g_stage[gi-1].out_w;
        end
        assign shl_w = in_w << SH;
        assign shr_w = (in_w >> SH) | ({N{fill}} & ~({N{1'b1}} >> SH));
        assign out_w = !amt[gi] ? in_w : (lbarr ? shr_w : shl_w);
    end

    assign dout = g_stage[B-1].out_w;
endmodule

module shift_unit_arbiter #(
    parameter int N = 32,
    parameter int B = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_data,
    input  logic [B-1:0] req0_amt,
    input  logic [1:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_data,
    input  logic [B-1:0] req1_amt,
    input  logic [1:0]   req1_op,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_data,
    output logic         rsp_id,
    output logic         busy
);
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {IDLE, EXEC, EXEC2} state_t;

    state_t       state_q;
    logic         prio_q;
    logic [N-1:0] data_q;
    logic [B-1:0] amt_q;
    logic [1:0]   op_q;
    logic         id_q;
    logic [N-1:0] partial_q;
    logic         rsp_valid_q;
    logic [N-1:0] rsp_data_q;
    logic         rsp_id_q;

    logic         can_grant_d;
    logic         gnt0_d;
    logic         gnt1_d;
    logic [B-1:0] neg_amt_d;
    logic [B-1:0] sh_amt_d;
    logic         sh_lbarr_d;
    logic         sh_asr_d;
    logic [N-1:0] sh_out;

    // A new op may start only if the response slot is free or being drained now.
    assign can_grant_d = (state_q == IDLE) && (!rsp_valid_q || rsp_ready);
    assign gnt0_d      = can_grant_d && req0_valid && (!req1_valid || !prio_q);
    assign gnt1_d      = can_grant_d && req1_valid && (!req0_valid || prio_q);

    assign req0_ready = gnt0_d;
    assign req1_ready = gnt1_d;

    // Second ROR pass is a left shift by N-amt, computed modulo 2**B.
    assign neg_amt_d  = ~amt_q + {{(B-1){1'b0}}, 1'b1};
    assign sh_amt_d   = (state_q == EXEC2) ? neg_amt_d : amt_q;
    assign sh_lbarr_d = (state_q == EXEC2) ? 1'b0 : (op_q != OP_SLL);
    assign sh_asr_d   = (state_q == EXEC2) ? 1'b0 : (op_q == OP_SRA);

    barrel_shifter #(.N(N), .B(B)) u_shifter (
        .din   (data_q),
        .amt   (sh_amt_d),
        .lbarr (sh_lbarr_d),
        .asr   (sh_asr_d),
        .dout  (sh_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            data_q      <= '0;
            amt_q       <= '0;
            op_q        <= '0;
            id_q        <= 1'b0;
            partial_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
        end else begin
            if (rsp_valid_q && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (gnt0_d || gnt1_d) begin
                        data_q  <= gnt1_d ? req1_data : req0_data;
                        amt_q   <= gnt1_d ? req1_amt  : req0_amt;
                        op_q    <= gnt1_d ? req1_op   : req0_op;
                        id_q    <= gnt1_d;
                        prio_q  <= ~gnt1_d;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (op_q != OP_ROR || amt_q == '0) begin
                        rsp_data_q  <= sh_out;
                        rsp_id_q    <= id_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        partial_q <= sh_out;
                        state_q   <= EXEC2;
                    end
                end
                EXEC2: begin
                    rsp_data_q  <= partial_q | sh_out;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE) || rsp_valid_q;
endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Directed bench for shift_unit_arbiter: vector table of single ops plus
// hand-written arbitration, backpressure, reset and operand-hold sequences.

module tb_shift_unit_arbiter;
    localparam int N = 32;
    localparam int B = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [N-1:0] req0_data, req1_data;
    logic [B-1:0] req0_amt, req1_amt;
    logic [1:0]   req0_op, req1_op;
    logic         rsp_valid, rsp_ready, rsp_id, busy;
    logic [N-1:0] rsp_data;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        bit          rq;
        logic [31:0] data;
        logic [4:0]  amt;
        logic [1:0]  op;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    shift_unit_arbiter #(.N(N), .B(B)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic set_req(input bit r, input bit v, input logic [31:0] d,
                           input logic [4:0] a, input logic [1:0] o);
        if (r) begin
            req1_valid = v; req1_data = d; req1_amt = a; req1_op = o;
        end else begin
            req0_valid = v; req0_data = d; req0_amt = a; req0_op = o;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        @(negedge clk);
        set_req(v.rq, 1'b1, v.data, v.amt, v.op);
        #1;
        chk($sformatf("v%0d_ready", idx), v.rq ? req1_ready : req0_ready, 1);
        @(posedge clk);
        @(negedge clk);
        set_req(v.rq, 1'b0, v.data, v.amt, v.op);
        lat = 1;
        #1;
        chk($sformatf("v%0d_busy", idx), busy, 1);
        while (!rsp_valid && lat < 8) begin
            @(negedge clk);
            #1;
            lat++;
        end
        chk($sformatf("v%0d_lat", idx), lat, v.lat);
        chk($sformatf("v%0d_data", idx), rsp_data, v.exp);
        chk($sformatf("v%0d_id", idx), rsp_id, v.rq);
        $display("vec %0d: rq=%0d op=%0d data=%h amt=%0d -> %h id=%0d lat=%0d",
                 idx, v.rq, v.op, v.data, v.amt, rsp_data, rsp_id, lat);
    endtask

    initial begin
        int ng, nr;
        vecs[0] = '{0, 32'h0000_0001, 5'd4,  2'b00, 32'h0000_0010, 2};
        vecs[1] = '{0, 32'h8000_00F0, 5'd4,  2'b01, 32'h0800_000F, 2};
        vecs[2] = '{0, 32'h8000_00F0, 5'd4,  2'b10, 32'hF800_000F, 2};
        vecs[3] = '{0, 32'h8000_00F0, 5'd4,  2'b11, 32'h0800_000F, 3};
        vecs[4] = '{0, 32'h0000_000F, 5'd4,  2'b11, 32'hF000_0000, 3};
        vecs[5] = '{0, 32'h8000_00F0, 5'd0,  2'b11, 32'h8000_00F0, 2};
        vecs[6] = '{0, 32'h1234_5678, 5'd31, 2'b11, 32'h2468_ACF0, 3};
        vecs[7] = '{1, 32'h7FFF_0000, 5'd16, 2'b10, 32'h0000_7FFF, 2};
        vecs[8] = '{1, 32'hDEAD_BEEF, 5'd31, 2'b00, 32'h8000_0000, 2};

        rst = 1'b1;
        rsp_ready = 1'b1;
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valid", rsp_valid, 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", {req1_ready, req0_ready}, 0);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Round-robin with both requesters continuously valid.
        @(negedge clk);
        set_req(0, 1'b1, 32'h1234_5678, 5'd8, 2'b00);
        set_req(1, 1'b1, 32'h8765_4321, 5'd12, 2'b10);
        ng = 0;
        nr = 0;
        for (int c = 0; c < 30 && nr < 4; c++) begin
            #1;
            if (ng < 4 && (req0_ready || req1_ready)) begin
                chk($sformatf("alt_gnt%0d", ng), {req1_ready, req0_ready}, (ng % 2) ? 2'b10 : 2'b01);
                $display("alt grant %0d: ready1=%0d ready0=%0d", ng, req1_ready, req0_ready);
                ng++;
            end
            if (rsp_valid) begin
                chk($sformatf("alt_id%0d", nr), rsp_id, nr % 2);
                chk($sformatf("alt_data%0d", nr), rsp_data, (nr % 2) ? 32'hFFF8_7654 : 32'h3456_7800);
                $display("alt rsp %0d: id=%0d data=%h", nr, rsp_id, rsp_data);
                nr++;
                if (nr == 4) begin
                    req0_valid = 1'b0;
                    req1_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        chk("alt_count", nr, 4);

        // Backpressure: result held while rsp_ready is low, no new grants.
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 32'h8000_00F0, 5'd4, 2'b01);
        set_req(1, 1'b1, 32'h0000_0003, 5'd2, 2'b00);
        #1;
        chk("bp_gnt0", {req1_ready, req0_ready}, 2'b01);
        @(negedge clk);
        @(negedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_valid%0d", k), rsp_valid, 1);
            chk($sformatf("bp_data%0d", k), rsp_data, 32'h0800_000F);
            chk($sformatf("bp_id%0d", k), rsp_id, 0);
            chk($sformatf("bp_nogrant%0d", k), {req1_ready, req0_ready}, 2'b00);
            $display("bp cycle %0d: valid=%0d data=%h id=%0d", k, rsp_valid, rsp_data, rsp_id);
            @(negedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_gnt1", {req1_ready, req0_ready}, 2'b10);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("bp_drained", rsp_valid, 0);
        @(negedge clk);
        #1;
        chk("bp_rsp_valid", rsp_valid, 1);
        chk("bp_rsp_id", rsp_id, 1);
        chk("bp_rsp_data", rsp_data, 32'h0000_000C);
        $display("bp release: id=%0d data=%h", rsp_id, rsp_data);

        // Reset while a ROR is in its second pass.
        @(negedge clk);
        set_req(0, 1'b1, 32'h8000_00F0, 5'd4, 2'b11);
        #1;
        chk("mr_ready", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mr_valid", rsp_valid, 0);
        chk("mr_data", rsp_data, 0);
        chk("mr_id", rsp_id, 0);
        chk("mr_busy", busy, 0);
        set_req(0, 1'b1, 32'h0000_0001, 5'd1, 2'b00);
        set_req(1, 1'b1, 32'hF000_0000, 5'd4, 2'b10);
        #1;
        chk("mr_prio", {req1_ready, req0_ready}, 2'b01);
        req0_valid = 1'b0;
        #1;
        chk("mr_gnt1", {req1_ready, req0_ready}, 2'b10);
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("mr_rsp_valid", rsp_valid, 1);
        chk("mr_rsp_data", rsp_data, 32'hFF00_0000);
        chk("mr_rsp_id", rsp_id, 1);
        $display("after reset: id=%0d data=%h", rsp_id, rsp_data);

        // Operand change after handshake must not affect the in-flight op.
        @(negedge clk);
        set_req(0, 1'b1, 32'hF0F0_0000, 5'd4, 2'b01);
        #1;
        chk("oc_ready", req0_ready, 1);
        @(negedge clk);
        set_req(0, 1'b0, 32'hFFFF_FFFF, 5'd9, 2'b00);
        @(negedge clk);
        #1;
        chk("oc_valid", rsp_valid, 1);
        chk("oc_data", rsp_data, 32'h0F0F_0000);
        chk("oc_id", rsp_id, 0);
        $display("operand hold: data=%h", rsp_data);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
